// File: rtl/call_panel_if.sv
// Button, door/engine status and call-output bundle between the panel and its controller.
interface call_panel_if;
  logic [2:0] interior_btn;
  logic [2:0] exterior_btn;
  logic [2:0] doors;
  logic [1:0] engine;
  logic [2:0] requests;
  logic [2:0] req_pulse;
  logic [2:0] interior_lamp;
  logic [2:0] exterior_lamp;
  logic       fault;

  modport master (
    output interior_btn, exterior_btn, doors, engine,
    input  requests, req_pulse, interior_lamp, exterior_lamp, fault
  );

  modport slave (
    input  interior_btn, exterior_btn, doors, engine,
    output requests, req_pulse, interior_lamp, exterior_lamp, fault
  );
endinterface

// File: rtl/call_panel.sv
// Three-floor call panel: synchronises and debounces six buttons, latches calls until the
// controller parks at the floor with doors open, and flags door/engine protocol violations.
module call_panel #(
  parameter int DEBOUNCE = 4,
  parameter int SERVE    = 3
) (
  input  logic         CLK,
  input  logic         RST,
  call_panel_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_HELD   = 2'd2;
  localparam logic [1:0] S_DISARM = 2'd3;

  // The count is compared before its increment, hence DEBOUNCE-1.
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [3:0] SRV_MAX = 4'(SERVE);

  logic [5:0] w_btn;
  logic [5:0] r_sync1;
  logic [5:0] r_sync2;
  logic [1:0] r_st  [6];
  logic [3:0] r_cnt [6];
  logic [5:0] r_press;
  logic [3:0] r_srv [3];
  logic [2:0] r_int_req;
  logic [2:0] r_ext_req;
  logic [2:0] r_req_d;
  logic [2:0] r_req_pulse;
  logic       r_fault;

  logic [2:0] w_cond;
  logic       w_viol;
  logic [2:0] w_clr;
  logic [2:0] w_int_set;
  logic [2:0] w_ext_set;
  logic [2:0] w_requests;

  // Bits 0..2 are cab buttons, 3..5 hall buttons.
  assign w_btn = {bus.exterior_btn, bus.interior_btn};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 6; i++) begin
        r_st[i]  <= S_IDLE;
        r_cnt[i] <= 4'd0;
      end
      r_press <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        r_press[i] <= 1'b0;
        case (r_st[i])
          S_IDLE: begin
            if (r_sync2[i]) begin
              r_st[i]  <= S_ARM;
              r_cnt[i] <= 4'd1;
            end
          end
          S_ARM: begin
            if (r_sync2[i]) begin
              r_cnt[i] <= r_cnt[i] + 4'd1;
              if (r_cnt[i] >= DB_LAST) begin
                r_st[i]    <= S_HELD;
                r_press[i] <= 1'b1;
              end
            end else begin
              r_st[i]  <= S_IDLE;
              r_cnt[i] <= 4'd0;
            end
          end
          S_HELD: begin
            if (!r_sync2[i]) begin
              r_st[i]  <= S_DISARM;
              r_cnt[i] <= 4'd1;
            end
          end
          S_DISARM: begin
            if (!r_sync2[i]) begin
              r_cnt[i] <= r_cnt[i] + 4'd1;
              if (r_cnt[i] >= DB_LAST) begin
                r_st[i] <= S_IDLE;
              end
            end else begin
              r_st[i] <= S_HELD;
            end
          end
          default: begin
            r_st[i]  <= S_IDLE;
            r_cnt[i] <= 4'd0;
          end
        endcase
      end
    end
  end

  // A violation is multiple doors open, the illegal engine code, or doors open while moving.
  assign w_viol = ((bus.doors & (bus.doors - 3'd1)) != 3'd0) ||
                  (bus.engine == 2'b01) ||
                  ((bus.doors != 3'd0) && (bus.engine != 2'b00));

  assign w_cond = {bus.doors == 3'b100, bus.doors == 3'b010, bus.doors == 3'b001} &
                  {3{bus.engine == 2'b00}};

  always_comb begin
    w_clr = '0;
    for (int f = 0; f < 3; f++) begin
      w_clr[f] = (r_srv[f] == SRV_MAX) && !w_viol;
    end
  end

  assign w_int_set = r_press[2:0] & ~w_cond;
  assign w_ext_set = r_press[5:3] & ~w_cond;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int f = 0; f < 3; f++) begin
        r_srv[f] <= 4'd0;
      end
    end else begin
      for (int f = 0; f < 3; f++) begin
        if (w_cond[f] && !w_viol) begin
          if (r_srv[f] != SRV_MAX) begin
            r_srv[f] <= r_srv[f] + 4'd1;
          end
        end else begin
          r_srv[f] <= 4'd0;
        end
      end
    end
  end

  // Clear dominates a same-cycle set.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_int_req   <= '0;
      r_ext_req   <= '0;
      r_req_d     <= '0;
      r_req_pulse <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_int_req   <= (r_int_req | w_int_set) & ~w_clr;
      r_ext_req   <= (r_ext_req | w_ext_set) & ~w_clr;
      r_req_d     <= w_requests;
      r_req_pulse <= w_requests & ~r_req_d;
      r_fault     <= r_fault | w_viol;
    end
  end

  assign w_requests        = r_int_req | r_ext_req;
  assign bus.requests      = w_requests;
  assign bus.req_pulse     = r_req_pulse;
  assign bus.interior_lamp = r_int_req;
  assign bus.exterior_lamp = r_ext_req;
  assign bus.fault         = r_fault;

endmodule

// File: tb/tb_call_panel.sv
// Directed bench for call_panel with DEBOUNCE=4, SERVE=3.
module tb_call_panel;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [2:0] pulse_acc;

  call_panel_if bus ();

  call_panel #(.DEBOUNCE(4), .SERVE(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.interior_btn = 3'b000;
    bus.exterior_btn = 3'b000;
    bus.doors        = 3'b000;
    bus.engine       = 2'b00;
    #12;
    chk("rst_requests", {1'b0, bus.requests}, 4'h0);
    chk("rst_pulse",    {1'b0, bus.req_pulse}, 4'h0);
    chk("rst_ilamp",    {1'b0, bus.interior_lamp}, 4'h0);
    chk("rst_elamp",    {1'b0, bus.exterior_lamp}, 4'h0);
    chk("rst_fault",    {3'b0, bus.fault}, 4'h0);
    tick();
    RST = 1'b1;
    tick();
    tick();

    // Hall press on floor 2: request six edges after the first sampling edge.
    bus.exterior_btn = 3'b010;
    repeat (6) tick();
    chk("hall2_early", {1'b0, bus.requests}, 4'h0);
    tick();
    chk("hall2_req",   {1'b0, bus.requests}, 4'h2);
    chk("hall2_pulse0", {1'b0, bus.req_pulse}, 4'h0);
    chk("hall2_elamp", {1'b0, bus.exterior_lamp}, 4'h2);
    chk("hall2_ilamp", {1'b0, bus.interior_lamp}, 4'h0);
    tick();
    chk("hall2_pulse", {1'b0, bus.req_pulse}, 4'h2);
    tick();
    chk("hall2_pulse_end", {1'b0, bus.req_pulse}, 4'h0);
    bus.exterior_btn = 3'b000;
    repeat (10) tick();

    // Bouncy cab button floor 3 never debounces.
    pulse_acc = 3'b000;
    bus.interior_btn = 3'b100; tick();
    bus.interior_btn = 3'b000; tick();
    bus.interior_btn = 3'b100; tick();
    bus.interior_btn = 3'b000;
    for (int i = 0; i < 12; i++) begin
      tick();
      pulse_acc = pulse_acc | bus.req_pulse;
    end
    chk("bounce_req",   {1'b0, bus.requests}, 4'h2);
    chk("bounce_pulse", {1'b0, pulse_acc}, 4'h0);

    // Cab call floor 1, then serve it.
    bus.interior_btn = 3'b001;
    repeat (7) tick();
    chk("cab1_req", {1'b0, bus.requests}, 4'h3);
    bus.interior_btn = 3'b000;
    repeat (8) tick();
    bus.doors = 3'b001;
    repeat (3) tick();
    chk("serve1_hold", {1'b0, bus.requests}, 4'h3);
    tick();
    chk("serve1_clr",   {1'b0, bus.requests}, 4'h2);
    chk("serve1_ilamp", {1'b0, bus.interior_lamp}, 4'h0);
    bus.exterior_btn = 3'b001;
    repeat (10) tick();
    chk("serve1_ignore", {1'b0, bus.exterior_lamp}, 4'h2);
    bus.exterior_btn = 3'b000;
    repeat (8) tick();
    bus.doors = 3'b000;
    tick();
    chk("serve1_after", {1'b0, bus.requests}, 4'h2);

    // Interrupted service on floor 3 restarts the count.
    bus.interior_btn = 3'b100;
    repeat (7) tick();
    chk("cab3_req", {1'b0, bus.requests}, 4'h6);
    bus.interior_btn = 3'b000;
    repeat (8) tick();
    bus.doors = 3'b100; tick(); tick();
    bus.doors = 3'b000; tick();
    bus.doors = 3'b100; tick(); tick();
    bus.doors = 3'b000; tick();
    chk("serve3_restart", {1'b0, bus.requests}, 4'h6);
    bus.doors = 3'b100;
    repeat (4) tick();
    chk("serve3_clr", {1'b0, bus.requests}, 4'h2);
    bus.doors = 3'b000;
    tick();

    // Doors open while moving: sticky fault, call never cleared.
    bus.engine = 2'b10;
    bus.doors  = 3'b010;
    tick();
    chk("fault_set", {3'b0, bus.fault}, 4'h1);
    repeat (6) tick();
    chk("fault_keep_req", {1'b0, bus.requests}, 4'h2);
    bus.engine = 2'b00;
    bus.doors  = 3'b000;
    tick();
    chk("fault_sticky", {3'b0, bus.fault}, 4'h1);

    // Reset mid-cycle with all buttons already pressed.
    RST = 1'b0;
    bus.interior_btn = 3'b111;
    bus.exterior_btn = 3'b111;
    #2;
    chk("rst2_fault", {3'b0, bus.fault}, 4'h0);
    chk("rst2_req",   {1'b0, bus.requests}, 4'h0);
    chk("rst2_elamp", {1'b0, bus.exterior_lamp}, 4'h0);
    tick();
    RST = 1'b1;
    repeat (6) tick();
    chk("all_early", {1'b0, bus.requests}, 4'h0);
    tick();
    chk("all_req",    {1'b0, bus.requests}, 4'h7);
    chk("all_ilamp",  {1'b0, bus.interior_lamp}, 4'h7);
    chk("all_elamp",  {1'b0, bus.exterior_lamp}, 4'h7);
    chk("all_pulse0", {1'b0, bus.req_pulse}, 4'h0);
    tick();
    chk("all_pulse",  {1'b0, bus.req_pulse}, 4'h7);
    tick();
    chk("all_pulse_end", {1'b0, bus.req_pulse}, 4'h0);
    chk("all_req_held",  {1'b0, bus.requests}, 4'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
